// File: rtl/knn_result_axis_tx.sv
// KNN result streamer: buffers {label, distance} pairs from the KNN core and emits each as a
// two-beat AXI-Stream transfer (label, then distance), grouping k results into a TLAST frame.
module knn_result_axis_tx #(
  parameter int unsigned dataWidth = 32,
  parameter int unsigned k         = 1,
  parameter int unsigned fifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 AXIS_out_wr_en,
  input  logic [31:0]          dataNameOut,
  input  logic [dataWidth-1:0] dataValueOut,
  output logic [31:0]          M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 M_AXIS_TLAST,
  output logic                 overflow,
  output logic [15:0]          frameCount
);

  localparam int unsigned PtrW   = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 32 + dataWidth;
  localparam int unsigned ResW   = 8;

  localparam logic [CntW-1:0] FullCnt = CntW'(fifoDepth);
  localparam logic [ResW-1:0] LastRes = ResW'(k - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSendName,
    StSendValue
  } state_e;

  // Result-pair buffer
  logic [EntryW-1:0] mem_q [fifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic [EntryW-1:0]    head_entry;
  logic [31:0]          head_name;
  logic [dataWidth-1:0] head_value;
  logic [31:0]          value_ext;

  // Output stage
  state_e            state_q, state_d;
  logic [31:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [31:0]       value_hold_q, value_hold_d;
  logic [ResW-1:0]   res_cnt_q, res_cnt_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              handshake;

  assign head_entry = mem_q[rd_ptr_q];
  assign head_name  = head_entry[EntryW-1 -: 32];
  assign head_value = head_entry[dataWidth-1:0];

  generate
    if (dataWidth < 32) begin : g_value_zext
      assign value_ext = {{(32 - dataWidth){1'b0}}, head_value};
    end else begin : g_value_trunc
      assign value_ext = head_value[31:0];
    end
  endgenerate

  // Full is judged on the pre-edge occupancy, so a same-edge pop cannot rescue a strobe.
  always_comb begin
    fifo_full  = (count_q == FullCnt);
    fifo_empty = (count_q == '0);
    push       = AXIS_out_wr_en && !fifo_full;
    handshake  = tvalid_q && M_AXIS_TREADY;
  end

  always_comb begin
    state_d      = state_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    value_hold_d = value_hold_q;
    res_cnt_d    = res_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    pop          = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          tdata_d      = head_name;
          value_hold_d = value_ext;
          tvalid_d     = 1'b1;
          tlast_d      = 1'b0;
          state_d      = StSendName;
        end
      end

      StSendName: begin
        if (handshake) begin
          tdata_d = value_hold_q;
          tlast_d = (res_cnt_q == LastRes);
          state_d = StSendValue;
        end
      end

      StSendValue: begin
        if (handshake) begin
          if (res_cnt_q == LastRes) begin
            res_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            res_cnt_d = res_cnt_q + ResW'(1);
          end
          tlast_d = 1'b0;
          // Chain straight into the next name beat to avoid a bubble.
          if (!fifo_empty) begin
            pop          = 1'b1;
            tdata_d      = head_name;
            value_hold_d = value_ext;
            state_d      = StSendName;
          end else begin
            tvalid_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end

      default: begin
        state_d  = StIdle;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (AXIS_out_wr_en && fifo_full);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {dataNameOut, dataValueOut};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      value_hold_q <= '0;
      res_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      value_hold_q <= value_hold_d;
      res_cnt_q    <= res_cnt_d;
      overflow_q   <= overflow_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign overflow      = overflow_q;
  assign frameCount    = frame_cnt_q;

endmodule

// File: tb/tb_knn_result_axis_tx.sv
// Directed bench for knn_result_axis_tx: three instances (k=1/16-bit, k=3, k=2/depth 2) on one
// clock and reset, with hand-computed beat sequences.
module tb_knn_result_axis_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en  [3];
  logic [31:0] name   [3];
  logic [31:0] val    [3];
  logic [15:0] val16;
  logic        tready [3];
  logic [31:0] tdata  [3];
  logic        tvalid [3];
  logic        tlast  [3];
  logic        ovf    [3];
  logic [15:0] fc     [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  knn_result_axis_tx #(.dataWidth(16), .k(1), .fifoDepth(4)) u_k1 (
    .clk(clk), .reset(reset), .AXIS_out_wr_en(wr_en[0]), .dataNameOut(name[0]),
    .dataValueOut(val16), .M_AXIS_TDATA(tdata[0]), .M_AXIS_TVALID(tvalid[0]),
    .M_AXIS_TREADY(tready[0]), .M_AXIS_TLAST(tlast[0]), .overflow(ovf[0]),
    .frameCount(fc[0])
  );

  knn_result_axis_tx #(.dataWidth(32), .k(3), .fifoDepth(4)) u_k3 (
    .clk(clk), .reset(reset), .AXIS_out_wr_en(wr_en[1]), .dataNameOut(name[1]),
    .dataValueOut(val[1]), .M_AXIS_TDATA(tdata[1]), .M_AXIS_TVALID(tvalid[1]),
    .M_AXIS_TREADY(tready[1]), .M_AXIS_TLAST(tlast[1]), .overflow(ovf[1]),
    .frameCount(fc[1])
  );

  knn_result_axis_tx #(.dataWidth(32), .k(2), .fifoDepth(2)) u_k2 (
    .clk(clk), .reset(reset), .AXIS_out_wr_en(wr_en[2]), .dataNameOut(name[2]),
    .dataValueOut(val[2]), .M_AXIS_TDATA(tdata[2]), .M_AXIS_TVALID(tvalid[2]),
    .M_AXIS_TREADY(tready[2]), .M_AXIS_TLAST(tlast[2]), .overflow(ovf[2]),
    .frameCount(fc[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One strobe; wr_en is held across exactly one rising edge.
  task automatic strobe(input int idx, input logic [31:0] n, input logic [31:0] v);
    @(negedge clk);
    wr_en[idx] = 1'b1;
    name[idx]  = n;
    val[idx]   = v;
    if (idx == 0) val16 = v[15:0];
    @(posedge clk);
    #1;
    wr_en[idx] = 1'b0;
  endtask

  // Waits (bounded) for a beat that will handshake on the next rising edge.
  task automatic expect_beat(input int idx, input string tag, input logic [31:0] exp_d,
                             input logic exp_l, input bit toggle, input int exp_wait);
    bit          ok = 1'b0;
    bit          stalled = 1'b0;
    int          waited = 0;
    logic [31:0] hold_d = '0;
    logic        hold_l = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (stalled) begin
        check_eq({tag, "_stall_data"}, tdata[idx], hold_d);
        check_eq({tag, "_stall_last"}, {31'b0, tlast[idx]}, {31'b0, hold_l});
      end
      if (toggle) tready[idx] = ~tready[idx];
      waited = c + 1;
      if (tvalid[idx] && tready[idx]) begin
        ok = 1'b1;
        break;
      end
      stalled = tvalid[idx];
      hold_d  = tdata[idx];
      hold_l  = tlast[idx];
    end
    if (!ok) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_data"}, tdata[idx], exp_d);
      check_eq({tag, "_last"}, {31'b0, tlast[idx]}, {31'b0, exp_l});
      if (exp_wait != 0) check_eq({tag, "_wait"}, waited, exp_wait);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      wr_en[i]  = 1'b0;
      name[i]   = '0;
      val[i]    = '0;
      tready[i] = 1'b0;
    end
    val16 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_tvalid", {31'b0, tvalid[1]}, 32'd0);
    check_eq("rst_tlast", {31'b0, tlast[1]}, 32'd0);
    check_eq("rst_tdata", tdata[1], 32'd0);
    check_eq("rst_ovf", {31'b0, ovf[1]}, 32'd0);
    check_eq("rst_fc", {16'b0, fc[1]}, 32'd0);
    reset = 1'b0;

    // k=1: single result, latency and frame count
    tready[0] = 1'b1;
    strobe(0, 32'h5, 32'h1A);
    expect_beat(0, "k1_name", 32'h5, 1'b0, 1'b0, 2);
    expect_beat(0, "k1_value", 32'h1A, 1'b1, 1'b0, 1);
    @(negedge clk);
    check_eq("k1_idle", {31'b0, tvalid[0]}, 32'd0);
    check_eq("k1_fc", {16'b0, fc[0]}, 32'd1);

    // 16-bit distance is zero-extended on the value beat
    strobe(0, 32'h77, 32'hBEEF);
    expect_beat(0, "w16_name", 32'h77, 1'b0, 1'b0, 2);
    expect_beat(0, "w16_value", 32'h0000_BEEF, 1'b1, 1'b0, 1);
    @(negedge clk);
    check_eq("w16_fc", {16'b0, fc[0]}, 32'd2);

    // k=3: three back-to-back strobes give six contiguous beats
    tready[1] = 1'b1;
    fork
      begin
        strobe(1, 32'h11, 32'h100);
        strobe(1, 32'h12, 32'h200);
        strobe(1, 32'h13, 32'h300);
      end
      begin
        expect_beat(1, "k3_n1", 32'h11, 1'b0, 1'b0, 3);
        expect_beat(1, "k3_v1", 32'h100, 1'b0, 1'b0, 1);
        expect_beat(1, "k3_n2", 32'h12, 1'b0, 1'b0, 1);
        expect_beat(1, "k3_v2", 32'h200, 1'b0, 1'b0, 1);
        expect_beat(1, "k3_n3", 32'h13, 1'b0, 1'b0, 1);
        expect_beat(1, "k3_v3", 32'h300, 1'b1, 1'b0, 1);
      end
    join
    @(negedge clk);
    check_eq("k3_fc", {16'b0, fc[1]}, 32'd1);
    check_eq("k3_ovf_clear", {31'b0, ovf[1]}, 32'd0);

    // Overflow: TREADY low, six strobes, sixth dropped
    tready[1] = 1'b0;
    for (int i = 0; i < 6; i++) strobe(1, 32'h21 + i, 32'h1001 + i);
    @(negedge clk);
    check_eq("ovf_flag", {31'b0, ovf[1]}, 32'd1);
    check_eq("ovf_hold_valid", {31'b0, tvalid[1]}, 32'd1);
    check_eq("ovf_hold_data", tdata[1], 32'h21);
    expect_beat(1, "ovf_n1", 32'h21, 1'b0, 1'b1, 1);
    expect_beat(1, "ovf_v1", 32'h1001, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_n2", 32'h22, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_v2", 32'h1002, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_n3", 32'h23, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_v3", 32'h1003, 1'b1, 1'b0, 1);
    expect_beat(1, "ovf_n4", 32'h24, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_v4", 32'h1004, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_n5", 32'h25, 1'b0, 1'b0, 1);
    expect_beat(1, "ovf_v5", 32'h1005, 1'b0, 1'b0, 1);
    @(negedge clk);
    check_eq("ovf_no_sixth", {31'b0, tvalid[1]}, 32'd0);
    check_eq("ovf_fc", {16'b0, fc[1]}, 32'd2);

    // Close the partial frame, then abandon a new one by reset after result 2's name beat
    fork
      strobe(1, 32'h26, 32'h1006);
      begin
        expect_beat(1, "fin_n", 32'h26, 1'b0, 1'b0, 3);
        expect_beat(1, "fin_v", 32'h1006, 1'b1, 1'b0, 1);
      end
    join
    fork
      begin
        strobe(1, 32'h41, 32'h2001);
        strobe(1, 32'h42, 32'h2002);
      end
      begin
        expect_beat(1, "rst_n1", 32'h41, 1'b0, 1'b0, 3);
        expect_beat(1, "rst_v1", 32'h2001, 1'b0, 1'b0, 1);
        expect_beat(1, "rst_n2", 32'h42, 1'b0, 1'b0, 1);
      end
    join
    @(posedge clk);
    #1;
    check_eq("pre_rst_value", tdata[1], 32'h2002);
    reset      = 1'b1;
    wr_en[1]   = 1'b1;
    name[1]    = 32'h99;
    val[1]     = 32'h9999;
    #1;
    check_eq("async_tvalid", {31'b0, tvalid[1]}, 32'd0);
    check_eq("async_tdata", tdata[1], 32'd0);
    check_eq("async_tlast", {31'b0, tlast[1]}, 32'd0);
    check_eq("async_fc", {16'b0, fc[1]}, 32'd0);
    check_eq("async_ovf", {31'b0, ovf[1]}, 32'd0);
    repeat (2) @(negedge clk);
    wr_en[1] = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_strobe_ignored", {31'b0, tvalid[1]}, 32'd0);
    fork
      begin
        strobe(1, 32'h51, 32'h3001);
        strobe(1, 32'h52, 32'h3002);
        strobe(1, 32'h53, 32'h3003);
      end
      begin
        expect_beat(1, "new_n1", 32'h51, 1'b0, 1'b0, 3);
        expect_beat(1, "new_v1", 32'h3001, 1'b0, 1'b0, 1);
        expect_beat(1, "new_n2", 32'h52, 1'b0, 1'b0, 1);
        expect_beat(1, "new_v2", 32'h3002, 1'b0, 1'b0, 1);
        expect_beat(1, "new_n3", 32'h53, 1'b0, 1'b0, 1);
        expect_beat(1, "new_v3", 32'h3003, 1'b1, 1'b0, 1);
      end
    join
    @(negedge clk);
    check_eq("new_fc", {16'b0, fc[1]}, 32'd1);

    // k=2, depth 2: TREADY toggling every cycle, outputs stable while stalled
    tready[2] = 1'b0;
    strobe(2, 32'h31, 32'hA1);
    strobe(2, 32'h32, 32'hA2);
    expect_beat(2, "tog_n1", 32'h31, 1'b0, 1'b1, 0);
    expect_beat(2, "tog_v1", 32'hA1, 1'b0, 1'b1, 0);
    expect_beat(2, "tog_n2", 32'h32, 1'b0, 1'b1, 0);
    expect_beat(2, "tog_v2", 32'hA2, 1'b1, 1'b1, 0);
    @(negedge clk);
    check_eq("tog_fc", {16'b0, fc[2]}, 32'd1);
    check_eq("tog_ovf", {31'b0, ovf[2]}, 32'd0);
    check_eq("tog_idle", {31'b0, tvalid[2]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/knn_result_axis_tx.md
KNN_RESULT_AXIS_TX -- requirements
Module: knn_result_axis_tx

Interface
REQ-001: Parameter dataWidth, default 32, width of the result distance value.
REQ-002: Parameter k, default 1, number of results per frame; range 1..255.
REQ-003: Parameter fifoDepth, default 4, result-pair buffer entries; power of 2, minimum 2.
REQ-004: Port clk  input  1  single clock; all logic on rising edge.
REQ-005: Port reset  input  1  asynchronous, active-high reset.
REQ-006: Port AXIS_out_wr_en  input  1  result strobe from the KNN core; one result per high cycle.
REQ-007: Port dataNameOut  input  32  result label, valid when AXIS_out_wr_en is high.
REQ-008: Port dataValueOut  input  dataWidth  result distance, valid when AXIS_out_wr_en is high.
REQ-009: Port M_AXIS_TDATA  output  32  outgoing stream beat.
REQ-010: Port M_AXIS_TVALID  output  1  beat valid.
REQ-011: Port M_AXIS_TREADY  input  1  downstream ready.
REQ-012: Port M_AXIS_TLAST  output  1  last beat of a k-result frame.
REQ-013: Port overflow  output  1  sticky flag: a result was dropped.
REQ-014: Port frameCount  output  16  completed frames sent, wraps 0xFFFF->0.

Function
REQ-015: The block SHALL capture {dataNameOut, dataValueOut} into the FIFO on every clk edge where AXIS_out_wr_en=1 and the FIFO is not full.
REQ-016: Full SHALL be evaluated from the registered occupancy before the edge; a strobe while full SHALL be dropped even if a pop occurs on the same edge, and SHALL set overflow.
REQ-017: Simultaneous push (not full) and pop SHALL leave occupancy unchanged and lose no data.
REQ-018: Each result SHALL be sent as two beats: name beat (TDATA=dataNameOut) then value beat (TDATA=dataValueOut zero-extended to 32 if dataWidth<32, low 32 bits if dataWidth>32).
REQ-019: FSM states IDLE, SEND_NAME, SEND_VALUE; TDATA, TVALID, TLAST SHALL be registered outputs.
REQ-020: IDLE -> SEND_NAME when FIFO non-empty: pop head, load name into TDATA, set TVALID.
REQ-021: SEND_NAME -> SEND_VALUE on TVALID&TREADY: load value into TDATA, TVALID stays 1 (no bubble).
REQ-022: SEND_VALUE on TVALID&TREADY: if FIFO non-empty pop and load next name (-> SEND_NAME, TVALID stays 1); else TVALID=0 (-> IDLE).
REQ-023: While TVALID=1 and TREADY=0, TDATA and TLAST SHALL hold stable.
REQ-024: Latency: strobe sampled at edge N into an empty FIFO with FSM IDLE -> TVALID=1 with name beat after edge N+1.
REQ-025: A result counter 0..k-1 SHALL increment on each value-beat handshake; TLAST=1 only on the value beat when counter=k-1; counter wraps to 0 and frameCount increments on that handshake.
REQ-026: TLAST SHALL be 0 on all name beats.
REQ-027: Sustained throughput SHALL be one beat per cycle while TREADY=1 and FIFO non-empty.

Reset
REQ-028: Asserting reset at any time SHALL immediately clear FIFO pointers/occupancy, FSM to IDLE, result counter to 0, TVALID=0, TLAST=0, TDATA=0, overflow=0, frameCount=0.
REQ-029: A frame in progress at reset SHALL be abandoned; the first result after reset release starts a new frame at counter 0.
REQ-030: AXIS_out_wr_en during reset SHALL be ignored.

Verification
REQ-031: k=1, TREADY=1, one strobe name=0x5, value=0x1A -> beats 0x5 (TLAST=0), 0x1A (TLAST=1) on consecutive cycles, TVALID first high one edge after capture, frameCount=1.
REQ-032: k=3, three strobes, TREADY=1 -> six contiguous beats, TLAST only on 6th, frameCount=1.
REQ-033: fifoDepth=4, TREADY=0, six back-to-back strobes -> first popped into output, four buffered, sixth dropped, overflow=1; releasing TREADY yields exactly 5 results in order.
REQ-034: TREADY toggled every other cycle during a k=2 frame -> TDATA/TLAST stable while stalled, no beat duplicated or lost.
REQ-035: Reset asserted after the name beat of result 2 of a k=3 frame -> outputs clear same cycle; next 3 results after release form a full frame with TLAST on 6th beat.
REQ-036: dataWidth=16, value=0xBEEF -> value beat TDATA=0x0000BEEF.
